// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: bundles the decode request, mul/div unit request/response,
// register-file writeback and hazard-status signals of md_issue_ctrl.
// master = the issue controller, slave = its environment (decode, unit, regfile).
interface md_issue_ctrl_if #(
  parameter int width_p          = 32,
  parameter int reg_addr_width_p = 5
);
  // Decode request
  logic                        instr_v_i;
  logic                        instr_ready_o;
  logic [2:0]                  funct3_i;
  logic [reg_addr_width_p-1:0] rd_i;
  logic [width_p-1:0]          opA_i;
  logic [width_p-1:0]          opB_i;

  // Request to the mul/div unit
  logic                        md_v_o;
  logic                        md_ready_i;
  logic [2:0]                  md_funct3_o;
  logic [width_p-1:0]          md_opA_o;
  logic [width_p-1:0]          md_opB_o;

  // Result from the mul/div unit
  logic                        md_v_i;
  logic [width_p-1:0]          md_result_i;
  logic                        md_yumi_o;

  // Register-file writeback
  logic                        wb_v_o;
  logic [reg_addr_width_p-1:0] wb_addr_o;
  logic [width_p-1:0]          wb_data_o;
  logic                        wb_grant_i;

  // Hazard status
  logic                        busy_o;
  logic [reg_addr_width_p-1:0] rd_pending_o;

  modport master (
    input  instr_v_i, funct3_i, rd_i, opA_i, opB_i,
    input  md_ready_i, md_v_i, md_result_i, wb_grant_i,
    output instr_ready_o, md_v_o, md_funct3_o, md_opA_o, md_opB_o,
    output md_yumi_o, wb_v_o, wb_addr_o, wb_data_o, busy_o, rd_pending_o
  );

  modport slave (
    output instr_v_i, funct3_i, rd_i, opA_i, opB_i,
    output md_ready_i, md_v_i, md_result_i, wb_grant_i,
    input  instr_ready_o, md_v_o, md_funct3_o, md_opA_o, md_opB_o,
    input  md_yumi_o, wb_v_o, wb_addr_o, wb_data_o, busy_o, rd_pending_o
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: single-entry issue controller for the M-extension mul/div unit.
// Accepts one instruction from decode, issues it to the unit, waits for the
// result and requests a register-file writeback (skipped when rd is x0).
// Optional macro MD_DIV0_FASTPATH_EN: divide/remainder by zero is resolved
// locally (all-ones for DIV/DIVU, dividend for REM/REMU) without using the unit.
module md_issue_ctrl #(
  parameter int width_p          = 32,
  parameter int reg_addr_width_p = 5
) (
  input logic             clk_i,
  input logic             reset_i,
  md_issue_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_e;

  state_e state_reg, state_next;

  logic [2:0]                  funct3_reg;
  logic [reg_addr_width_p-1:0] rd_reg;
  logic [width_p-1:0]          opa_reg;
  logic [width_p-1:0]          opb_reg;
  logic [width_p-1:0]          result_reg;

  logic instr_ready;
  logic md_v;
  logic md_yumi;
  logic wb_v;
  logic busy;
  logic accept;
  logic div0_fast;
  logic [width_p-1:0] fast_result;

  assign accept = bus.instr_v_i && instr_ready;

`ifdef MD_DIV0_FASTPATH_EN
  // funct3[2] set selects DIV/DIVU/REM/REMU; funct3[1] set selects the remainders.
  assign div0_fast   = bus.funct3_i[2] && (bus.opB_i == '0);
  assign fast_result = bus.funct3_i[1] ? bus.opA_i : '1;
`else
  assign div0_fast   = 1'b0;
  assign fast_result = '0;
`endif

  // State register; reset drops straight back to IDLE, abandoning any operation.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake decode; outputs depend only on state and md_v_i.
  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    md_v        = 1'b0;
    md_yumi     = 1'b0;
    wb_v        = 1'b0;
    busy        = 1'b1;
    unique case (state_reg)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (bus.instr_v_i) begin
          if (div0_fast) begin
            state_next = (bus.rd_i == '0) ? IDLE : WB;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        md_v = 1'b1;
        if (bus.md_ready_i) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        md_yumi = bus.md_v_i;
        if (bus.md_v_i) begin
          // Results for x0 are consumed but never written back.
          state_next = (rd_reg == '0) ? IDLE : WB;
        end
      end
      WB: begin
        wb_v = 1'b1;
        if (bus.wb_grant_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand/destination capture on accept; result capture from the unit or fast path.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      funct3_reg <= '0;
      rd_reg     <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      result_reg <= '0;
    end else begin
      if (accept) begin
        funct3_reg <= bus.funct3_i;
        rd_reg     <= bus.rd_i;
        opa_reg    <= bus.opA_i;
        opb_reg    <= bus.opB_i;
        if (div0_fast) begin
          result_reg <= fast_result;
        end
      end
      if (md_yumi) begin
        result_reg <= bus.md_result_i;
      end
    end
  end

  assign bus.instr_ready_o = instr_ready;
  assign bus.md_v_o        = md_v;
  assign bus.md_funct3_o   = funct3_reg;
  assign bus.md_opA_o      = opa_reg;
  assign bus.md_opB_o      = opb_reg;
  assign bus.md_yumi_o     = md_yumi;
  assign bus.wb_v_o        = wb_v;
  // Writeback fields and the pending destination read as zero when not meaningful.
  assign bus.wb_addr_o     = wb_v ? rd_reg : '0;
  assign bus.wb_data_o     = wb_v ? result_reg : '0;
  assign bus.busy_o        = busy;
  assign bus.rd_pending_o  = busy ? rd_reg : '0;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: randomized bench for md_issue_ctrl. The mul/div unit and
// expected writeback values come from an arithmetic M-extension model.
module tb_md_issue_ctrl;

`ifdef MD_DIV0_FASTPATH_EN
  localparam bit FASTPATH = 1'b1;
`else
  localparam bit FASTPATH = 1'b0;
`endif

  logic clk_i;
  logic reset_i;
  int   n_checks;
  int   n_errors;
  int   txn_cnt;

  md_issue_ctrl_if #(.width_p(32), .reg_addr_width_p(5)) bus_if ();

  md_issue_ctrl #(.width_p(32), .reg_addr_width_p(5)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RISC-V M-extension semantics, including divide-by-zero and overflow rules.
  function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    logic signed [31:0] ia, ib;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    ia = a;
    ib = b;
    r  = 32'd0;
    case (f3)
      3'd0: begin p = za * zb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * zb; r = p[63:32]; end
      3'd3: begin p = za * zb; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a :
                ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One full instruction: accept, optional unit round trip, optional writeback.
  // With noise set, inputs that must be ignored in a state are randomized.
  task automatic run_txn(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input int rdy_dly, input int rsp_dly,
                         input int gnt_dly, input bit noise);
    logic [31:0] res;
    bit fast;
    res  = md_ref(f3, a, b);
    fast = FASTPATH && f3[2] && (b == 32'd0);
    txn_cnt++;
    $display("txn %0d: f3=%0d rd=%0d a=%h b=%h result=%h path=%s", txn_cnt, f3, rd, a, b,
             res, fast ? "fast" : "unit");
    bus_if.instr_v_i = 1'b1;
    bus_if.funct3_i  = f3;
    bus_if.rd_i      = rd;
    bus_if.opA_i     = a;
    bus_if.opB_i     = b;
    bus_if.md_v_i    = noise ? 1'($urandom) : 1'b0;
    #4;
    check_val("idle_ready", 32'(bus_if.instr_ready_o), 32'd1);
    check_val("idle_busy", 32'(bus_if.busy_o), 32'd0);
    check_val("idle_yumi", 32'(bus_if.md_yumi_o), 32'd0);
    check_val("idle_md_v", 32'(bus_if.md_v_o), 32'd0);
    tick();
    bus_if.instr_v_i = 1'b0;
    bus_if.funct3_i  = 3'($urandom);
    bus_if.rd_i      = 5'($urandom);
    bus_if.opA_i     = $urandom;
    bus_if.opB_i     = $urandom;
    if (!fast) begin
      for (int k = 0; k <= rdy_dly; k++) begin
        bus_if.md_ready_i = (k == rdy_dly);
        bus_if.md_v_i     = noise ? 1'($urandom) : 1'b0;
        bus_if.wb_grant_i = noise ? 1'($urandom) : 1'b0;
        bus_if.instr_v_i  = noise ? 1'($urandom) : 1'b0;
        #4;
        check_val("issue_md_v", 32'(bus_if.md_v_o), 32'd1);
        check_val("issue_funct3", 32'(bus_if.md_funct3_o), 32'(f3));
        check_val("issue_opA", bus_if.md_opA_o, a);
        check_val("issue_opB", bus_if.md_opB_o, b);
        check_val("issue_ready", 32'(bus_if.instr_ready_o), 32'd0);
        check_val("issue_busy", 32'(bus_if.busy_o), 32'd1);
        check_val("issue_rd_pend", 32'(bus_if.rd_pending_o), 32'(rd));
        check_val("issue_yumi", 32'(bus_if.md_yumi_o), 32'd0);
        check_val("issue_wb_v", 32'(bus_if.wb_v_o), 32'd0);
        tick();
      end
      for (int k = 0; k <= rsp_dly; k++) begin
        bus_if.md_v_i      = (k == rsp_dly);
        bus_if.md_result_i = (k == rsp_dly) ? res : $urandom;
        bus_if.md_ready_i  = noise ? 1'($urandom) : 1'b0;
        bus_if.wb_grant_i  = noise ? 1'($urandom) : 1'b0;
        bus_if.instr_v_i   = noise ? 1'($urandom) : 1'b0;
        #4;
        check_val("wait_md_v", 32'(bus_if.md_v_o), 32'd0);
        check_val("wait_yumi", 32'(bus_if.md_yumi_o), 32'(k == rsp_dly));
        check_val("wait_busy", 32'(bus_if.busy_o), 32'd1);
        check_val("wait_ready", 32'(bus_if.instr_ready_o), 32'd0);
        check_val("wait_wb_v", 32'(bus_if.wb_v_o), 32'd0);
        tick();
      end
    end
    if (rd != 5'd0) begin
      for (int k = 0; k <= gnt_dly; k++) begin
        bus_if.wb_grant_i = (k == gnt_dly);
        bus_if.md_v_i     = noise ? 1'($urandom) : 1'b0;
        bus_if.md_ready_i = noise ? 1'($urandom) : 1'b0;
        bus_if.instr_v_i  = noise ? 1'($urandom) : 1'b0;
        #4;
        check_val("wb_v", 32'(bus_if.wb_v_o), 32'd1);
        check_val("wb_addr", 32'(bus_if.wb_addr_o), 32'(rd));
        check_val("wb_data", bus_if.wb_data_o, res);
        check_val("wb_md_v", 32'(bus_if.md_v_o), 32'd0);
        check_val("wb_yumi", 32'(bus_if.md_yumi_o), 32'd0);
        check_val("wb_ready", 32'(bus_if.instr_ready_o), 32'd0);
        check_val("wb_busy", 32'(bus_if.busy_o), 32'd1);
        check_val("wb_rd_pend", 32'(bus_if.rd_pending_o), 32'(rd));
        tick();
      end
    end
    bus_if.wb_grant_i = 1'b0;
    bus_if.md_v_i     = 1'b0;
    bus_if.md_ready_i = 1'b0;
    bus_if.instr_v_i  = 1'b0;
    #4;
    check_val("done_busy", 32'(bus_if.busy_o), 32'd0);
    check_val("done_ready", 32'(bus_if.instr_ready_o), 32'd1);
    check_val("done_wb_v", 32'(bus_if.wb_v_o), 32'd0);
    check_val("done_rd_pend", 32'(bus_if.rd_pending_o), 32'd0);
    check_val("done_md_v", 32'(bus_if.md_v_o), 32'd0);
    tick();
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_md_v"}, 32'(bus_if.md_v_o), 32'd0);
    check_val({tag, "_yumi"}, 32'(bus_if.md_yumi_o), 32'd0);
    check_val({tag, "_wb_v"}, 32'(bus_if.wb_v_o), 32'd0);
    check_val({tag, "_busy"}, 32'(bus_if.busy_o), 32'd0);
    check_val({tag, "_wb_addr"}, 32'(bus_if.wb_addr_o), 32'd0);
    check_val({tag, "_wb_data"}, bus_if.wb_data_o, 32'd0);
    check_val({tag, "_rd_pend"}, 32'(bus_if.rd_pending_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf3;
    logic [4:0]  rrd;
    logic [31:0] ra, rb;
    n_checks = 0;
    n_errors = 0;
    txn_cnt  = 0;
    reset_i            = 1'b1;
    bus_if.instr_v_i   = 1'b0;
    bus_if.funct3_i    = 3'd0;
    bus_if.rd_i        = 5'd0;
    bus_if.opA_i       = 32'd0;
    bus_if.opB_i       = 32'd0;
    bus_if.md_ready_i  = 1'b0;
    bus_if.md_v_i      = 1'b1;
    bus_if.md_result_i = 32'hDEAD_BEEF;
    bus_if.wb_grant_i  = 1'b0;
    #3;
    check_quiet("rst");
    check_val("rst_opA", bus_if.md_opA_o, 32'd0);
    tick();
    tick();
    reset_i       = 1'b0;
    bus_if.md_v_i = 1'b0;
    #4;
    check_quiet("post_rst");
    tick();

    // Directed cases
    run_txn(3'd0, 5'd7, 32'd3, 32'd5, 0, 0, 0, 1'b0);                    // MUL 3*5 -> x7
    run_txn(3'd0, 5'd4, 32'h1234_5678, 32'h9ABC_DEF0, 10, 1, 2, 1'b1);   // long ISSUE stall
    run_txn(3'd5, 5'd3, 32'd100, 32'd0, 1, 1, 0, 1'b0);                  // DIVU by zero
    run_txn(3'd6, 5'd9, 32'hFFFF_FFF9, 32'd0, 0, 0, 1, 1'b0);            // REM by zero
    run_txn(3'd3, 5'd0, 32'h1234_0000, 32'h0001_0000, 0, 2, 0, 1'b1);    // MULHU -> x0
    run_txn(3'd4, 5'd0, 32'd5, 32'd0, 0, 0, 0, 1'b1);                    // DIV by zero -> x0

    // Reset between clock edges while waiting for the unit
    $display("txn reset-in-WAIT: MUL rd=12 abandoned");
    bus_if.instr_v_i = 1'b1;
    bus_if.funct3_i  = 3'd0;
    bus_if.rd_i      = 5'd12;
    bus_if.opA_i     = 32'd7;
    bus_if.opB_i     = 32'd9;
    tick();
    bus_if.instr_v_i  = 1'b0;
    bus_if.md_ready_i = 1'b1;
    tick();
    bus_if.md_ready_i  = 1'b0;
    bus_if.md_v_i      = 1'b1;
    bus_if.md_result_i = 32'd63;
    #1;
    check_val("rstw_yumi_pre", 32'(bus_if.md_yumi_o), 32'd1);
    check_val("rstw_busy_pre", 32'(bus_if.busy_o), 32'd1);
    #1;
    reset_i = 1'b1;
    #1;
    check_quiet("rstw");
    tick();
    reset_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #4;
      check_quiet("rstw_after");
      tick();
    end
    bus_if.md_v_i = 1'b0;
    run_txn(3'd1, 5'd12, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 1'b0);           // recovery

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      rrd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_txn(rf3, rrd, ra, rb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have parameter width_p, default 32: operand and result width.
REQ-002 SHALL have parameter reg_addr_width_p, default 5: destination register index width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports instr_v_i  input  1, and instr_ready_o  output  1: request handshake from decode; an instruction is accepted when both are high.
REQ-006 SHALL have ports funct3_i  input  3, rd_i  input  reg_addr_width_p, opA_i and opB_i  input  width_p: M-extension operation, destination register and operands.
REQ-007 SHALL have ports md_v_o  output  1, md_ready_i  input  1, md_funct3_o  output  3, and md_opA_o / md_opB_o  output  width_p: request to the mul/div unit.
REQ-008 SHALL have ports md_v_i  input  1, md_result_i  input  width_p, and md_yumi_o  output  1: result from the mul/div unit.
REQ-009 SHALL have ports wb_v_o  output  1, wb_addr_o  output  reg_addr_width_p, wb_data_o  output  width_p, and wb_grant_i  input  1: register-file writeback request.
REQ-010 SHALL have ports busy_o  output  1 (operation in flight) and rd_pending_o  output  reg_addr_width_p (its destination, for hazard checks).

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT and WB.
REQ-012 In IDLE: instr_ready_o=1; on accept, SHALL register funct3, rd and both operands and go to ISSUE.
REQ-013 In ISSUE: md_v_o=1 with registered operands/funct3 held stable; when md_ready_i=1, SHALL go to WAIT.
REQ-014 In WAIT: md_yumi_o=md_v_i; when md_v_i=1, SHALL capture md_result_i in the same cycle and go to WB.
REQ-015 In WB: wb_v_o=1, wb_addr_o=rd, wb_data_o=captured result; when wb_grant_i=1, SHALL go to IDLE.
REQ-016 If the registered rd is 0, SHALL still consume the result, bypass WB and return to IDLE from WAIT.
REQ-017 instr_ready_o SHALL be 1 only in IDLE; no new instruction is accepted in the cycle WB completes.
REQ-018 busy_o SHALL be 1 in every state except IDLE; rd_pending_o SHALL equal the registered rd while busy_o=1 and 0 otherwise.
REQ-019 md_yumi_o SHALL be 0 outside WAIT; md_v_i in any other state is ignored.
REQ-020 Minimum latency SHALL be: accept at cycle N, md_v_o at N+1, and wb_v_o one cycle after md_v_i.
REQ-021 wb_v_o, md_v_o and md_yumi_o SHALL be mutually exclusive in every cycle.

Reset
REQ-022 On reset_i=1, SHALL enter IDLE immediately, without waiting for a clock edge.
REQ-023 During and after reset, all registered outputs SHALL read 0: md_v_o, md_yumi_o, wb_v_o, busy_o, wb_addr_o, wb_data_o and rd_pending_o.
REQ-024 Reset asserted mid-operation SHALL abandon the operation with no writeback.

Configuration
REQ-025 Macro MD_DIV0_FASTPATH_EN SHALL be optional.
REQ-026 When MD_DIV0_FASTPATH_EN is defined and an accepted DIV/DIVU/REM/REMU has opB=0, SHALL skip ISSUE and WAIT and go directly to WB (or to IDLE if rd=0).
REQ-027 The fast-path result SHALL be all-ones for DIV/DIVU, and opA for REM/REMU.
REQ-028 When MD_DIV0_FASTPATH_EN is not defined, all operations SHALL be issued to the unit.

Verification
REQ-029 Bench SHALL cover: MUL opA=3, opB=5, rd=7; unit model returns 15 -> wb_v_o=1, wb_addr_o=7, wb_data_o=0x0000000F; state reaches IDLE after grant.
REQ-030 Bench SHALL cover: md_ready_i held 0 for 10 cycles in ISSUE -> md_v_o high all 10 cycles with md_opA_o/md_opB_o unchanged; instr_ready_o=0 throughout.
REQ-031 Bench SHALL cover: DIVU opA=100, opB=0, rd=3 with MD_DIV0_FASTPATH_EN -> md_v_o never asserted; wb_data_o=0xFFFFFFFF. Same stimulus without the macro -> md_v_o asserted.
REQ-032 Bench SHALL cover: REM opA=0xFFFFFFF9, opB=0 with MD_DIV0_FASTPATH_EN -> wb_data_o=0xFFFFFFF9.
REQ-033 Bench SHALL cover: MULHU with rd=0 and result 0x1234 -> md_yumi_o pulses once; wb_v_o stays 0; busy_o drops the next cycle.
REQ-034 Bench SHALL cover: reset_i asserted between clock edges in WAIT -> busy_o and md_yumi_o fall before the next edge; a later md_v_i=1 produces md_yumi_o=0 and no writeback.
